branch_predictor_gshare: RTL and testbench

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_sat_counter.sv | 30 +++
 rtl/branch_predictor_gshare.sv | 123 ++++++++++++
 tb/tb_branch_predictor_gshare.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the gshare/bimodal branch predictor
//
// Purpose : predictor FSM state encoding and the counter initial-value helper.
// Ports   : none (package).
// Macro   : BP_GSHARE_HISTORY_EN is consumed by branch_predictor_gshare, not here.

package bp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_t;

  // Weakly-not-taken: the largest value whose MSB is still 0.
  function automatic logic [3:0] ctr_init_value(input int ctr_width);
    return 4'((1 << (ctr_width - 1)) - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - next-value logic for a saturating up/down counter
//
// Purpose : counter + 1 on taken, counter - 1 on not-taken, clamped to
//           [0, 2^CTR_WIDTH-1].
// Ports   : counter      in  CTR_WIDTH  current counter value
//           taken        in  1          resolved direction
//           next_counter out CTR_WIDTH  updated counter value

module bp_sat_counter #(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] counter,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] next_counter
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN = '0;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

  always_comb begin
    next_counter = counter;
    if (taken) begin
      if (counter != CTR_MAX) next_counter = counter + CTR_ONE;
    end else begin
      if (counter != CTR_MIN) next_counter = counter - CTR_ONE;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare (or bimodal) branch direction predictor
//
// Purpose : pattern history table of saturating counters, looked up by the
//           fetch stage and trained by the decode stage. After reset the
//           table is swept to weakly-not-taken, one entry per cycle.
// Macro   : BP_GSHARE_HISTORY_EN - when defined, a global history register is
//           XORed into both indices (gshare); otherwise PC-only (bimodal).
// Ports   : clk                   in  1            clock, rising edge
//           rst                   in  1            synchronous active-high reset
//           IF_PC_Slice           in  TABLE_WIDTH  fetch lookup PC bits
//           IF_PredictBranchTaken out 1            combinational prediction
//           ID_PC_Slice           in  TABLE_WIDTH  resolved branch PC bits
//           ID_AttemptBranch      in  1            a branch resolved this cycle
//           ID_BranchTaken        in  1            resolved direction
//           Ready                 out 1            table initialisation done

module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int TABLE_WIDTH = 3,
  parameter int CTR_WIDTH   = 2,
  parameter int HIST_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TABLE_WIDTH-1:0] IF_PC_Slice,
  output logic                   IF_PredictBranchTaken,
  input  logic [TABLE_WIDTH-1:0] ID_PC_Slice,
  input  logic                   ID_AttemptBranch,
  input  logic                   ID_BranchTaken,
  output logic                   Ready
);

  localparam int TABLE_SIZE = 1 << TABLE_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_init_value(CTR_WIDTH));

  if (CTR_WIDTH < 2 || CTR_WIDTH > 4 || HIST_WIDTH < 1 || HIST_WIDTH > TABLE_WIDTH) begin : g_bad_params
    $error("branch_predictor_gshare: CTR_WIDTH or HIST_WIDTH out of range");
  end

  bp_state_t              state;
  bp_state_t              next_state;
  logic [TABLE_WIDTH-1:0] sweep_idx;
  logic                   sweep_done;
  logic [CTR_WIDTH-1:0]   pht [TABLE_SIZE];
  logic [TABLE_WIDTH-1:0] lookup_idx;
  logic [TABLE_WIDTH-1:0] update_idx;
  logic [CTR_WIDTH-1:0]   next_counter;
  logic                   accept_update;

  assign accept_update = (state == ST_RUN) && ID_AttemptBranch;

`ifdef BP_GSHARE_HISTORY_EN
  logic [HIST_WIDTH-1:0] ghr;

  // Both indices use the GHR value held before this cycle's shift.
  assign lookup_idx = IF_PC_Slice ^ TABLE_WIDTH'(ghr);
  assign update_idx = ID_PC_Slice ^ TABLE_WIDTH'(ghr);

  // The size cast drops the old MSB; written this way it also covers HIST_WIDTH=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (accept_update) begin
      ghr <= HIST_WIDTH'({ghr, ID_BranchTaken});
    end
  end
`else
  assign lookup_idx = IF_PC_Slice;
  assign update_idx = ID_PC_Slice;
`endif

  assign sweep_done = &sweep_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: if (sweep_done) next_state = ST_RUN;
      ST_RUN:  next_state = ST_RUN;
    endcase
  end

  // Wraps back to 0 on the final INIT cycle; the value is unused in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_idx <= '0;
    end else if (state == ST_INIT) begin
      sweep_idx <= sweep_idx + TABLE_WIDTH'(1);
    end
  end

  bp_sat_counter #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_sat_counter (
    .counter      (pht[update_idx]),
    .taken        (ID_BranchTaken),
    .next_counter (next_counter)
  );

  // The table has no reset: only the sweep rewrites it, and rst freezes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        pht[sweep_idx] <= CTR_INIT;
      end else if (ID_AttemptBranch) begin
        pht[update_idx] <= next_counter;
      end
    end
  end

  // No bypass: a same-cycle update to the looked-up entry shows up next cycle.
  assign IF_PredictBranchTaken = (state == ST_RUN) && pht[lookup_idx][CTR_WIDTH-1];
  assign Ready                 = (state == ST_RUN);

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - self-checking bench for branch_predictor_gshare

module tb_branch_predictor_gshare;

  localparam int TW = 3;
  localparam int CW = 2;
  localparam int HW = 2;
  localparam int N  = 1 << TW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [TW-1:0] if_pc = '0;
  logic [TW-1:0] id_pc = '0;
  logic          attempt = 1'b0;
  logic          taken = 1'b0;
  logic          pred;
  logic          ready;

  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .TABLE_WIDTH (TW),
    .CTR_WIDTH   (CW),
    .HIST_WIDTH  (HW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .IF_PC_Slice           (if_pc),
    .IF_PredictBranchTaken (pred),
    .ID_PC_Slice           (id_pc),
    .ID_AttemptBranch      (attempt),
    .ID_BranchTaken        (taken),
    .Ready                 (ready)
  );

  typedef struct {
    logic  pred;
    logic  ready;
    int    want_pred;
    int    want_ready;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  int m_pht [N];
  int m_ghr   = 0;
  bit m_run   = 1'b0;
  int m_sweep = 0;
  bit m_valid = 1'b0;

  function automatic int model_idx(input int s);
`ifdef BP_GSHARE_HISTORY_EN
    return (s ^ m_ghr) & (N - 1);
`else
    return s & (N - 1);
`endif
  endfunction

  task automatic check(input logic obs, input logic expv, input string tag);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, then advance the model.
  task automatic step(input bit r, input int ifs, input bit att, input int ids,
                      input bit tk, input int want_pred, input int want_ready,
                      input string tag);
    exp_t e;
    exp_t got;
    int   idx;
    @(negedge clk);
    rst     = r;
    if_pc   = TW'(ifs);
    attempt = att;
    id_pc   = TW'(ids);
    taken   = tk;
    if (m_valid) begin
      e.pred       = m_run ? logic'((m_pht[model_idx(ifs)] >> (CW - 1)) & 1) : 1'b0;
      e.ready      = m_run;
      e.want_pred  = want_pred;
      e.want_ready = want_ready;
      e.tag        = tag;
      exp_q.push_back(e);
    end
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check(pred,  got.pred,  {got.tag, ".pred"});
      check(ready, got.ready, {got.tag, ".ready"});
      if (got.want_pred >= 0)  check(pred,  logic'(got.want_pred),  {got.tag, ".pred_spec"});
      if (got.want_ready >= 0) check(ready, logic'(got.want_ready), {got.tag, ".ready_spec"});
    end
    if (r) begin
      m_run   = 1'b0;
      m_sweep = 0;
      m_ghr   = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (!m_run) begin
        m_pht[m_sweep] = (1 << (CW - 1)) - 1;
        if (m_sweep == N - 1) m_run = 1'b1;
        m_sweep++;
      end else if (att) begin
        idx = model_idx(ids);
        if (tk && m_pht[idx] < (1 << CW) - 1) m_pht[idx]++;
        else if (!tk && m_pht[idx] > 0) m_pht[idx]--;
`ifdef BP_GSHARE_HISTORY_EN
        m_ghr = ((m_ghr << 1) | int'(tk)) & ((1 << HW) - 1);
`endif
      end
    end
  endtask

  initial begin
    // Reset for one cycle, then sweep while the decode stage hammers taken updates.
    step(1, 0, 0, 0, 0, -1, -1, "rst0");
    for (int k = 0; k < N; k++) step(0, k, 1, k, 1, 0, 0, $sformatf("init_upd%0d", k));

    // Ready now high; every entry must read weakly-not-taken and GHR must be clear.
    for (int s = 0; s < N; s++) step(0, s, 0, 0, 0, 0, 1, $sformatf("run_read%0d", s));

`ifdef BP_GSHARE_HISTORY_EN
    step(0, 0, 1, 0, 1, 0, 1, "g_upd0");
    step(0, 1, 0, 0, 0, 1, 1, "g_s1_entry0");
    step(0, 0, 0, 0, 0, 0, 1, "g_s0_entry1");
`else
    step(0, 0, 1, 0, 1, 0, 1, "sat_t1");
    step(0, 0, 1, 0, 1, 1, 1, "sat_t2");
    step(0, 0, 1, 0, 1, 1, 1, "sat_t3");
    step(0, 0, 1, 0, 1, 1, 1, "sat_t4");
    step(0, 0, 1, 0, 0, 1, 1, "sat_n1");
    step(0, 0, 1, 0, 0, 1, 1, "sat_n2");
    step(0, 0, 0, 0, 0, 0, 1, "sat_end");
    step(0, 4, 1, 4, 0, 0, 1, "floor_n1");
    step(0, 4, 1, 4, 0, 0, 1, "floor_n2");
    step(0, 4, 1, 4, 0, 0, 1, "floor_n3");
    step(0, 4, 1, 4, 1, 0, 1, "floor_t1");
    step(0, 4, 1, 4, 1, 0, 1, "floor_t2");
    step(0, 4, 0, 0, 0, 1, 1, "floor_end");
`endif

    for (int k = 0; k < 40; k++)
      step(0, $urandom_range(N - 1), 1'($urandom_range(1)), $urandom_range(N - 1),
           1'($urandom_range(1)), -1, -1, $sformatf("rand%0d", k));

    // Reset from RUN, then a same-cycle lookup/update collision at entry 2.
    step(1, 0, 0, 0, 0, -1, -1, "rst_run");
    for (int k = 0; k < N; k++) step(0, k, 0, 0, 0, 0, 0, $sformatf("init2_%0d", k));
    step(0, 2, 1, 2, 1, 0, 1, "bypass_same");
`ifdef BP_GSHARE_HISTORY_EN
    step(0, 3, 0, 0, 0, 1, 1, "bypass_next");
`else
    step(0, 2, 0, 0, 0, 1, 1, "bypass_next");
`endif

    // Reset mid-sweep at index 5: the sweep must restart from 0.
    step(1, 0, 0, 0, 0, -1, -1, "rst_a");
    for (int k = 0; k < 5; k++) step(0, k, 0, 0, 0, 0, 0, $sformatf("part_%0d", k));
    step(1, 0, 0, 0, 0, 0, 0, "rst_mid");
    for (int k = 0; k < N; k++) step(0, k, 0, 0, 0, 0, 0, $sformatf("init3_%0d", k));
    step(0, 1, 0, 0, 0, 0, 1, "ready_after_mid");
    step(0, 6, 0, 0, 0, 0, 1, "read_after_mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
